// File: rtl/nebula_pkg.sv
// Shared types for the nebula ejection/reassembly stage.
// Flit framing encoding, eject FSM states and framing helpers.
package nebula_pkg;

    typedef enum logic [1:0] {
        FT_HEAD   = 2'b00,
        FT_BODY   = 2'b01,
        FT_TAIL   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        EJ_IDLE   = 1'b0,
        EJ_STREAM = 1'b1
    } eject_state_e;

    function automatic logic is_first(input flit_type_e t);
        return (t == FT_HEAD) || (t == FT_SINGLE);
    endfunction

    function automatic logic is_last(input flit_type_e t);
        return (t == FT_TAIL) || (t == FT_SINGLE);
    endfunction

endpackage

// File: rtl/nebula_vc_fifo.sv
// Per-VC flit buffer: synchronous FIFO with combinational head read.
// Simultaneous push and pop is allowed, also when full.
module nebula_vc_fifo #(
    parameter int W     = 66,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/nebula_eject_reasm.sv
// Router local-port ejection: per-VC buffering, whole-packet round-robin release.
// Optional stat_pkts/stat_flits counters under NEBULA_EJECT_STATS_EN.
module nebula_eject_reasm
    import nebula_pkg::*;
#(
    parameter int VCS        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int PAYLOAD_W  = 64,
    localparam int VC_W      = $clog2(VCS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flit_valid,
    input  logic [1:0]           flit_type,
    input  logic [VC_W-1:0]      flit_vc,
    input  logic [PAYLOAD_W-1:0] flit_payload,
    output logic                 credit_valid,
    output logic [VC_W-1:0]      credit_vc,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [PAYLOAD_W-1:0] pkt_data,
    output logic                 pkt_first,
    output logic                 pkt_last,
    output logic [VC_W-1:0]      pkt_vc,
    output logic                 err_overflow,
    output logic                 err_proto
`ifdef NEBULA_EJECT_STATS_EN
    ,
    output logic [31:0]          stat_pkts,
    output logic [31:0]          stat_flits
`endif
);

    localparam int FW = PAYLOAD_W + 2;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [VCS-1:0] fifo_push, fifo_pop;
    logic [VCS-1:0] fifo_full, fifo_empty;
    logic [FW-1:0]  fifo_head [VCS];
    logic [FW-1:0]  flit_word;

    eject_state_e   state_q, state_d;
    logic [VC_W-1:0] sel_vc_q, sel_vc_d;
    logic [VC_W-1:0] rr_q, rr_d;
    logic [VCS-1:0] in_pkt_q, in_pkt_d;
    logic [CW-1:0]  pkt_cnt_q [VCS];
    logic [CW-1:0]  pkt_cnt_d [VCS];
    logic           err_overflow_q, err_overflow_d;
    logic           err_proto_q, err_proto_d;
    logic           credit_valid_q, credit_valid_d;
    logic [VC_W-1:0] credit_vc_q, credit_vc_d;

    logic [FW-1:0]  head_w;
    flit_type_e     head_type, in_type;
    logic           streaming, pop_fire, pop_last;
    logic           in_fire, found;
    logic [VC_W-1:0] cand;
    logic [VCS-1:0] cnt_inc, cnt_dec;

    assign flit_word = {flit_type, flit_payload};

    for (genvar g = 0; g < VCS; g++) begin : g_vc
        nebula_vc_fifo #(
            .W    (FW),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst_n(rst_n),
            .push (fifo_push[g]),
            .din  (flit_word),
            .pop  (fifo_pop[g]),
            .full (fifo_full[g]),
            .empty(fifo_empty[g]),
            .dout (fifo_head[g])
        );
    end

    always_comb begin
        head_w    = fifo_head[sel_vc_q];
        head_type = flit_type_e'(head_w[FW-1 -: 2]);
        in_type   = flit_type_e'(flit_type);
        streaming = (state_q == EJ_STREAM) && !fifo_empty[sel_vc_q];
        pop_fire  = streaming && pkt_ready;
        pop_last  = pop_fire && is_last(head_type);

        fifo_pop = '0;
        fifo_pop[sel_vc_q] = pop_fire;
        // A full VC still accepts when its head leaves in the same cycle
        in_fire = flit_valid && (!fifo_full[flit_vc] || fifo_pop[flit_vc]);
        fifo_push = '0;
        fifo_push[flit_vc] = in_fire;

        err_overflow_d = err_overflow_q | (flit_valid && !in_fire);
        err_proto_d    = err_proto_q;
        in_pkt_d       = in_pkt_q;
        if (in_fire) begin
            err_proto_d = err_proto_q
                | (in_pkt_q[flit_vc] == is_first(in_type));
            in_pkt_d[flit_vc] = (in_type == FT_HEAD)
                | ((in_type == FT_BODY) & in_pkt_q[flit_vc]);
        end

        for (int v = 0; v < VCS; v++) begin
            cnt_inc[v] = in_fire && (flit_vc == VC_W'(v)) && is_last(in_type);
            cnt_dec[v] = pop_last && (sel_vc_q == VC_W'(v));
            pkt_cnt_d[v] = pkt_cnt_q[v];
            if (cnt_inc[v] && !cnt_dec[v]) begin
                pkt_cnt_d[v] = pkt_cnt_q[v] + 1'b1;
            end else if (cnt_dec[v] && !cnt_inc[v]) begin
                pkt_cnt_d[v] = pkt_cnt_q[v] - 1'b1;
            end
        end

        state_d  = state_q;
        sel_vc_d = sel_vc_q;
        rr_d     = rr_q;
        found    = 1'b0;
        cand     = '0;
        unique case (state_q)
            EJ_IDLE: begin
                for (int i = 0; i < VCS; i++) begin
                    cand = VC_W'((int'(rr_q) + i) % VCS);
                    if (!found && (pkt_cnt_q[cand] != '0)) begin
                        found    = 1'b1;
                        sel_vc_d = cand;
                        state_d  = EJ_STREAM;
                    end
                end
            end
            EJ_STREAM: begin
                if (pop_last) begin
                    state_d = EJ_IDLE;
                    rr_d = (sel_vc_q == VC_W'(VCS - 1)) ? '0 : sel_vc_q + 1'b1;
                end
            end
        endcase

        credit_valid_d = pop_fire;
        credit_vc_d    = pop_fire ? sel_vc_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= EJ_IDLE;
            sel_vc_q       <= '0;
            rr_q           <= '0;
            in_pkt_q       <= '0;
            err_overflow_q <= 1'b0;
            err_proto_q    <= 1'b0;
            credit_valid_q <= 1'b0;
            credit_vc_q    <= '0;
            for (int v = 0; v < VCS; v++) begin
                pkt_cnt_q[v] <= '0;
            end
        end else begin
            state_q        <= state_d;
            sel_vc_q       <= sel_vc_d;
            rr_q           <= rr_d;
            in_pkt_q       <= in_pkt_d;
            err_overflow_q <= err_overflow_d;
            err_proto_q    <= err_proto_d;
            credit_valid_q <= credit_valid_d;
            credit_vc_q    <= credit_vc_d;
            for (int v = 0; v < VCS; v++) begin
                pkt_cnt_q[v] <= pkt_cnt_d[v];
            end
        end
    end

    assign pkt_valid    = streaming;
    assign pkt_data     = streaming ? head_w[PAYLOAD_W-1:0] : '0;
    assign pkt_first    = streaming && is_first(head_type);
    assign pkt_last     = streaming && is_last(head_type);
    assign pkt_vc       = streaming ? sel_vc_q : '0;
    assign credit_valid = credit_valid_q;
    assign credit_vc    = credit_vc_q;
    assign err_overflow = err_overflow_q;
    assign err_proto    = err_proto_q;

`ifdef NEBULA_EJECT_STATS_EN
    logic [31:0] stat_pkts_q, stat_pkts_d;
    logic [31:0] stat_flits_q, stat_flits_d;

    always_comb begin
        stat_pkts_d  = stat_pkts_q + {31'd0, pop_last};
        stat_flits_d = stat_flits_q + {31'd0, pop_fire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts_q  <= '0;
            stat_flits_q <= '0;
        end else begin
            stat_pkts_q  <= stat_pkts_d;
            stat_flits_q <= stat_flits_d;
        end
    end

    assign stat_pkts  = stat_pkts_q;
    assign stat_flits = stat_flits_q;
`endif

endmodule

// File: tb/tb_nebula_eject_reasm.sv
// Directed bench for nebula_eject_reasm: latency, packet order, stalls,
// overflow, framing errors and asynchronous reset.
module tb_nebula_eject_reasm;
    import nebula_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flit_valid;
    logic [1:0]  flit_type;
    logic [1:0]  flit_vc;
    logic [63:0] flit_payload;
    logic        credit_valid;
    logic [1:0]  credit_vc;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [63:0] pkt_data;
    logic        pkt_first;
    logic        pkt_last;
    logic [1:0]  pkt_vc;
    logic        err_overflow;
    logic        err_proto;
`ifdef NEBULA_EJECT_STATS_EN
    logic [31:0] stat_pkts;
    logic [31:0] stat_flits;
`endif

    always #5 clk = ~clk;

    nebula_eject_reasm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flit_valid  (flit_valid),
        .flit_type   (flit_type),
        .flit_vc     (flit_vc),
        .flit_payload(flit_payload),
        .credit_valid(credit_valid),
        .credit_vc   (credit_vc),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_data    (pkt_data),
        .pkt_first   (pkt_first),
        .pkt_last    (pkt_last),
        .pkt_vc      (pkt_vc),
        .err_overflow(err_overflow),
        .err_proto   (err_proto)
`ifdef NEBULA_EJECT_STATS_EN
        ,
        .stat_pkts   (stat_pkts),
        .stat_flits  (stat_flits)
`endif
    );

    int errs = 0;
    int checks = 0;
    int credit_cnt = 0;
    logic [19:0] obs_q[$];
    logic [19:0] exp_q[$];

    // Record each handshake as {vc, first, last, data[15:0]}
    always @(negedge clk) begin
        if (rst_n && pkt_valid && pkt_ready) begin
            obs_q.push_back({pkt_vc, pkt_first, pkt_last, pkt_data[15:0]});
        end
        if (rst_n && credit_valid) begin
            credit_cnt++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int vc, input flit_type_e t,
                        input logic [63:0] p);
        flit_valid   = 1'b1;
        flit_vc      = 2'(vc);
        flit_type    = t;
        flit_payload = p;
        step();
        flit_valid   = 1'b0;
        flit_vc      = 2'd0;
        flit_type    = 2'd0;
        flit_payload = '0;
    endtask

    task automatic expect_out(input int vc, input bit f, input bit l,
                              input int d);
        exp_q.push_back({2'(vc), f, l, 16'(d)});
    endtask

    task automatic chk_out(input string tag);
        logic [19:0] o;
        chk($sformatf("%s_count", tag), 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            o = 'x;
            if (i < obs_q.size()) o = obs_q[i];
            chk($sformatf("%s_%0d", tag, i), 64'(o), 64'(exp_q[i]));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step();
        obs_q.delete();
        credit_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        flit_valid = 1'b0;
        flit_type = 2'd0;
        flit_vc = 2'd0;
        flit_payload = '0;
        pkt_ready = 1'b0;
        step(3);
        chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("rst_credit_valid", 64'(credit_valid), 64'd0);
        chk("rst_err_overflow", 64'(err_overflow), 64'd0);
        chk("rst_err_proto", 64'(err_proto), 64'd0);
        chk("rst_pkt_data", pkt_data, 64'd0);
        rst_n = 1'b1;
        step(2);

        // SINGLE latency and credit timing
        pkt_ready = 1'b1;
        send(2, FT_SINGLE, 64'hA5);
        chk("t1_valid_t1", 64'(pkt_valid), 64'd0);
        step();
        chk("t1_valid_t2", 64'(pkt_valid), 64'd1);
        chk("t1_first", 64'(pkt_first), 64'd1);
        chk("t1_last", 64'(pkt_last), 64'd1);
        chk("t1_vc", 64'(pkt_vc), 64'd2);
        chk("t1_data", pkt_data, 64'hA5);
        chk("t1_credit_t2", 64'(credit_valid), 64'd0);
        step();
        chk("t1_credit_t3", 64'(credit_valid), 64'd1);
        chk("t1_credit_vc", 64'(credit_vc), 64'd2);
        chk("t1_valid_t3", 64'(pkt_valid), 64'd0);
        step();
        obs_q.delete();

        // Interleaved arrival, VC1 completes first
        send(0, FT_HEAD, 64'h100);
        send(1, FT_HEAD, 64'h110);
        send(0, FT_BODY, 64'h101);
        send(1, FT_TAIL, 64'h111);
        send(0, FT_TAIL, 64'h102);
        step(10);
        expect_out(1, 1, 0, 'h110);
        expect_out(1, 0, 1, 'h111);
        expect_out(0, 1, 0, 'h100);
        expect_out(0, 0, 0, 'h101);
        expect_out(0, 0, 1, 'h102);
        chk_out("t2_order");

        // Round robin from pointer 0
        do_reset();
        pkt_ready = 1'b0;
        send(0, FT_SINGLE, 64'h300);
        send(1, FT_SINGLE, 64'h301);
        send(2, FT_SINGLE, 64'h302);
        send(3, FT_SINGLE, 64'h303);
        step(2);
        chk("t3_stall_vc", 64'(pkt_vc), 64'd0);
        pkt_ready = 1'b1;
        step(12);
        expect_out(0, 1, 1, 'h300);
        expect_out(1, 1, 1, 'h301);
        expect_out(2, 1, 1, 'h302);
        expect_out(3, 1, 1, 'h303);
        chk_out("t3_rr");

        // Refill: VC1 overtakes VC3 because pointer sits at 1 after VC0
        pkt_ready = 1'b0;
        send(0, FT_SINGLE, 64'h310);
        send(3, FT_SINGLE, 64'h313);
        send(1, FT_SINGLE, 64'h311);
        step(2);
        pkt_ready = 1'b1;
        step(10);
        expect_out(0, 1, 1, 'h310);
        expect_out(1, 1, 1, 'h311);
        expect_out(3, 1, 1, 'h313);
        chk_out("t3_refill");

        // Long backpressure during a 3-flit packet
        pkt_ready = 1'b0;
        credit_cnt = 0;
        send(2, FT_HEAD, 64'h400);
        send(2, FT_BODY, 64'h401);
        send(2, FT_TAIL, 64'h402);
        step(2);
        chk("t4_valid", 64'(pkt_valid), 64'd1);
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t4_hold_data_%0d", i), pkt_data, 64'h400);
            chk($sformatf("t4_hold_vc_%0d", i), 64'(pkt_vc), 64'd2);
            step();
        end
        chk("t4_no_credit", 64'(credit_cnt), 64'd0);
        pkt_ready = 1'b1;
        step(8);
        expect_out(2, 1, 0, 'h400);
        expect_out(2, 0, 0, 'h401);
        expect_out(2, 0, 1, 'h402);
        chk_out("t4_release");
        chk("t4_credits", 64'(credit_cnt), 64'd3);

        // Overflow of VC1
        do_reset();
        pkt_ready = 1'b0;
        send(1, FT_HEAD, 64'h500);
        for (int i = 1; i < 7; i++) send(1, FT_BODY, 64'h500 + 64'(i));
        send(1, FT_TAIL, 64'h507);
        chk("t5_ovf_before", 64'(err_overflow), 64'd0);
        send(1, FT_SINGLE, 64'h508);
        chk("t5_ovf_set", 64'(err_overflow), 64'd1);
        step(3);
        chk("t5_ovf_sticky", 64'(err_overflow), 64'd1);
        chk("t5_no_credit", 64'(credit_cnt), 64'd0);
        pkt_ready = 1'b1;
        step(20);
        chk("t5_credits", 64'(credit_cnt), 64'd8);
        expect_out(1, 1, 0, 'h500);
        for (int i = 1; i < 7; i++) expect_out(1, 0, 0, 'h500 + i);
        expect_out(1, 0, 1, 'h507);
        chk_out("t5_drain");
        chk("t5_ovf_after", 64'(err_overflow), 64'd1);
        chk("t5_proto_clean", 64'(err_proto), 64'd0);
        chk("t5_idle", 64'(pkt_valid), 64'd0);
        send(0, FT_SINGLE, 64'h77);
        step(4);
        expect_out(0, 1, 1, 'h77);
        chk_out("t5_after");

        // Framing error: BODY outside a packet
        send(3, FT_BODY, 64'h600);
        chk("t6_proto_set", 64'(err_proto), 64'd1);
        step(3);
        chk("t6_proto_sticky", 64'(err_proto), 64'd1);
        chk("t6_body_not_pkt", 64'(pkt_valid), 64'd0);

        // Asynchronous reset mid-stream
        pkt_ready = 1'b0;
        send(1, FT_HEAD, 64'h610);
        send(1, FT_TAIL, 64'h611);
        step(2);
        chk("t6_stream", 64'(pkt_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(pkt_valid), 64'd0);
        chk("t6_rst_data", pkt_data, 64'd0);
        chk("t6_rst_first", 64'(pkt_first), 64'd0);
        chk("t6_rst_vc", 64'(pkt_vc), 64'd0);
        chk("t6_rst_proto", 64'(err_proto), 64'd0);
        chk("t6_rst_ovf", 64'(err_overflow), 64'd0);
        chk("t6_rst_credit", 64'(credit_valid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pkt_ready = 1'b1;
        step(5);
        chk("t6_empty_valid", 64'(pkt_valid), 64'd0);
        chk("t6_empty_out", 64'(obs_q.size()), 64'd0);
        send(3, FT_SINGLE, 64'h620);
        step(3);
        expect_out(3, 1, 1, 'h620);
        chk_out("t6_fresh");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/nebula_eject_reasm.md
Name: nebula_eject_reasm

Overview:
Ejection stage on the router local port, between the router's local output link and the node-side consumer. Per-VC flit buffering with credit return to the router. Releases whole packets on a valid/ready stream: once a packet is selected, its flits leave back-to-back with no interleaving between VCs. Round-robin arbitration across VCs that hold at least one complete packet.

Parameters:
VCS, 4, number of virtual channels
FIFO_DEPTH, 8, flits per VC buffer; equals upstream initial credits per VC
PAYLOAD_W, 64, flit payload width
VC_W, $clog2(VCS), VC index width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset
flit_valid  in  1  flit present this cycle (credit-gated upstream, no ready)
flit_type  in  2  flit_type_e: HEAD, BODY, TAIL, SINGLE
flit_vc  in  VC_W  VC of incoming flit
flit_payload  in  PAYLOAD_W  flit data
credit_valid  out  1  one credit returned
credit_vc  out  VC_W  VC of returned credit
pkt_valid  out  1  output flit valid
pkt_ready  in  1  consumer accepts
pkt_data  out  PAYLOAD_W  output flit payload
pkt_first  out  1  first flit of packet (HEAD or SINGLE)
pkt_last  out  1  last flit of packet (TAIL or SINGLE)
pkt_vc  out  VC_W  VC of current packet
err_overflow  out  1  sticky: flit arrived to full VC buffer
err_proto  out  1  sticky: framing violation

Behaviour:
- Single clock clk; asynchronous active-low reset rst_n. Reset: all FIFOs empty, pkt counts 0, in_pkt bits 0, FSM IDLE, RR pointer 0, every output 0.
- Ingress: flit_valid=1 writes flit (type+payload) into FIFO[flit_vc] at the edge.
- FIFO full: flit dropped, err_overflow set. No credit is generated for a dropped flit.
- Framing, per VC in_pkt bit:
  - HEAD sets it; TAIL clears it; SINGLE leaves it at 0.
  - BODY/TAIL with in_pkt=0, or HEAD/SINGLE with in_pkt=1, sets err_proto. The flit is still stored and in_pkt updates normally.
- pkt_cnt[v] increments on each stored TAIL or SINGLE and decrements when the last flit leaves. Simultaneous increment and decrement leaves it unchanged.
- FSM IDLE:
  - If any pkt_cnt[v]>0, pick the first such v at or after the RR pointer (wrapping).
  - Register sel_vc; go to STREAM.
- FSM STREAM:
  - pkt_valid=1 driven from FIFO[sel_vc] head.
  - Output handshake is pkt_valid&&pkt_ready; the head pops on each handshake.
  - Outputs hold stable while pkt_ready=0.
  - On the handshake of a flit with pkt_last: pkt_cnt[sel_vc]--, RR pointer = sel_vc+1 mod VCS, return to IDLE.
  - The FIFO never underruns in STREAM, because the packet is complete before selection.
- Latency: SINGLE arriving at cycle t with the block idle gives pkt_valid=1 at t+2. Each packet costs one IDLE bubble cycle.
- Credits: one pop per cycle at most. credit_valid/credit_vc are registered and assert the cycle after each pop.
- Same-VC push and pop in one cycle is legal; occupancy is unchanged, including when the FIFO is full.
- Reset mid-packet discards all state; upstream shares rst_n and restores its credits to FIFO_DEPTH.

Optional Feature:
NEBULA_EJECT_STATS_EN
- Defined: adds outputs stat_pkts (32) and stat_flits (32). They count delivered packets (last-flit handshakes) and delivered flits, wrap modulo 2^32, and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- nebula_pkg: flit_type_e (HEAD=2'b00, BODY=2'b01, TAIL=2'b10, SINGLE=2'b11) and an eject FSM state enum.
- Sub-module nebula_vc_fifo, parameterised by width and depth. Ports: push, pop, full, empty, head data. Instantiated VCS times in a generate loop.

Test Plan:
- SINGLE on VC2, payload 0xA5, pkt_ready=1 at t -> pkt_valid at t+2 with pkt_first=pkt_last=1, pkt_vc=2, pkt_data=0xA5. credit_valid with credit_vc=2 at t+3.
- HEAD,BODY,TAIL on VC0 interleaved with HEAD,TAIL on VC1, VC1 tail first -> VC1 packet emitted whole, then VC0's three flits contiguous. No interleaving on the output.
- Complete packets on all 4 VCs with pointer 0 -> output order VC0,1,2,3. Refill VC0 and VC3 -> order VC0 then VC3.
- pkt_ready held 0 for 20 cycles during a 3-flit packet -> pkt_data/pkt_vc stable, no credits returned. Release -> 3 handshakes, 3 credits.
- 9 flits to VC1 with depth 8 and no drain -> 9th dropped, err_overflow=1 and stays set. 8 credits only after draining.
- BODY on idle VC3 -> err_proto=1. Assert rst_n=0 mid-stream -> all outputs 0 asynchronously, FIFOs empty after release.
